// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl_if: line-sampler inputs and decoded-bit/framing outputs of the USB receive sequencer
interface usb_rx_ctrl_if;
    logic       bit_tick;
    logic       dp;
    logic       dm;
    logic       bit_out;
    logic       bit_valid;
    logic       pkt_start;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;
    modport master (output bit_tick, dp, dm,
                    input  bit_out, bit_valid, pkt_start, pkt_done, pkt_err, err_code, busy);
    modport slave  (input  bit_tick, dp, dm,
                    output bit_out, bit_valid, pkt_start, pkt_done, pkt_err, err_code, busy);
endinterface

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB full-speed receive sequencer - NRZI decode, SYNC acquisition, unstuffing, EOP detection
module usb_rx_ctrl #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int MAX_BITS       = 8216,
    parameter int IDLE_BITS      = 2
) (
    input logic        clk,
    input logic        rst_b,
    usb_rx_ctrl_if.slave bus
);
    localparam int BW = $clog2(MAX_BITS + 1);
    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} state_t;

    state_t        state, state_n;
    logic          prev_line, prev_n;
    logic [2:0]    zero_cnt, zero_n;
    logic [2:0]    ones_cnt, ones_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [1:0]    se0_cnt, se0_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          valid_q, out_q, start_q, done_q, err_q;
    logic          valid_n, out_n, start_n, done_n, err_n;
    logic [1:0]    code_q, code_n;

    wire j   = bus.dp & ~bus.dm;
    wire k   = ~bus.dp & bus.dm;
    wire se0 = ~bus.dp & ~bus.dm;
    wire se1 = bus.dp & bus.dm;
    wire dec = bus.dp == prev_line;
    wire act = state == SYNC || state == DATA || state == EOP;

    always_comb begin
        state_n = state;
        prev_n  = prev_line;
        zero_n  = zero_cnt;
        ones_n  = ones_cnt;
        bit_n   = bit_cnt;
        se0_n   = se0_cnt;
        idle_n  = idle_cnt;
        valid_n = 1'b0;
        out_n   = 1'b0;
        start_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = 2'd0;
        if (bus.bit_tick) begin
            if (j || k)
                prev_n = bus.dp;
            if (se1 && act) begin
                err_n  = 1'b1;
                code_n = 2'd3;
            end else begin
                case (state)
                    IDLE: if (k) begin
                        state_n = SYNC;
                        zero_n  = 3'd1;
                    end
                    SYNC: if (se0) begin
                        err_n = 1'b1;
                    end else if (!dec) begin
                        zero_n = (zero_cnt == 3'd7) ? zero_cnt : zero_cnt + 3'd1;
                    end else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
                        state_n = DATA;
                        start_n = 1'b1;
                        ones_n  = 3'd1;
                        bit_n   = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                    DATA: if (se0) begin
                        state_n = EOP;
                        se0_n   = 2'd1;
                    end else if (ones_cnt == 3'd6) begin
                        // a stuffed zero carries no data; a one here is a stuffing violation
                        err_n  = dec;
                        code_n = 2'd1;
                        ones_n = 3'd0;
                    end else if (bit_cnt == BW'(MAX_BITS)) begin
                        err_n  = 1'b1;
                        code_n = 2'd3;
                    end else begin
                        valid_n = 1'b1;
                        out_n   = dec;
                        bit_n   = bit_cnt + 1'b1;
                        ones_n  = dec ? ones_cnt + 3'd1 : 3'd0;
                    end
                    EOP: if (se0) begin
                        err_n  = se0_cnt == 2'd3;
                        code_n = 2'd2;
                        se0_n  = se0_cnt + 2'd1;
                    end else if (j && se0_cnt >= 2'd2) begin
                        state_n = IDLE;
                        done_n  = bit_cnt[2:0] == 3'd0;
                        err_n   = bit_cnt[2:0] != 3'd0;
                        code_n  = 2'd2;
                    end else begin
                        err_n  = 1'b1;
                        code_n = 2'd2;
                    end
                    ERR: if (j) begin
                        state_n = (idle_cnt == IW'(IDLE_BITS - 1)) ? IDLE : ERR;
                        idle_n  = (idle_cnt == IW'(IDLE_BITS - 1)) ? '0 : idle_cnt + 1'b1;
                    end else begin
                        idle_n = '0;
                    end
                    default: state_n = IDLE;
                endcase
            end
            if (err_n) begin
                state_n = ERR;
                zero_n  = 3'd0;
                ones_n  = 3'd0;
                bit_n   = '0;
                se0_n   = 2'd0;
                idle_n  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            prev_line <= 1'b1;
            zero_cnt  <= 3'd0;
            ones_cnt  <= 3'd0;
            bit_cnt   <= '0;
            se0_cnt   <= 2'd0;
            idle_cnt  <= '0;
            valid_q   <= 1'b0;
            out_q     <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state     <= state_n;
            prev_line <= prev_n;
            zero_cnt  <= zero_n;
            ones_cnt  <= ones_n;
            bit_cnt   <= bit_n;
            se0_cnt   <= se0_n;
            idle_cnt  <= idle_n;
            valid_q   <= valid_n;
            out_q     <= out_n;
            start_q   <= start_n;
            done_q    <= done_n;
            err_q     <= err_n;
            code_q    <= code_n;
        end
    end

    assign bus.bit_out   = out_q;
    assign bus.bit_valid = valid_q;
    assign bus.pkt_start = start_q;
    assign bus.pkt_done  = done_q;
    assign bus.pkt_err   = err_q;
    assign bus.err_code  = code_q;
    assign bus.busy      = act;
endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed NRZI line stimulus with hand-computed decode, framing and error expectations
module tb_usb_rx_ctrl;
    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic tick = 1'b0, l_dp = 1'b1, l_dm = 1'b0, sel = 1'b0, ln = 1'b1;
    int   ntests = 0, nfail = 0;
    int   cnt_valid = 0, cnt_start = 0, cnt_done = 0, cnt_err = 0;
    logic [1:0] last_code = 2'd0;
    logic bq[$];
    int   sv, ss, sd, se, sb;

    always #5 clk = ~clk;

    usb_rx_ctrl_if i0 ();
    usb_rx_ctrl_if i1 ();
    assign i0.bit_tick = tick & ~sel;
    assign i1.bit_tick = tick & sel;
    assign i0.dp = l_dp;
    assign i0.dm = l_dm;
    assign i1.dp = l_dp;
    assign i1.dm = l_dm;

    usb_rx_ctrl dut (.clk(clk), .rst_b(rst_b), .bus(i0));
    usb_rx_ctrl #(.MAX_BITS(16)) dut16 (.clk(clk), .rst_b(rst_b), .bus(i1));

    wire       m_valid = sel ? i1.bit_valid : i0.bit_valid;
    wire       m_out   = sel ? i1.bit_out   : i0.bit_out;
    wire       m_start = sel ? i1.pkt_start : i0.pkt_start;
    wire       m_done  = sel ? i1.pkt_done  : i0.pkt_done;
    wire       m_err   = sel ? i1.pkt_err   : i0.pkt_err;
    wire       m_busy  = sel ? i1.busy      : i0.busy;
    wire [1:0] m_code  = sel ? i1.err_code  : i0.err_code;
    wire [7:0] m_all   = {m_out, m_valid, m_start, m_done, m_err, m_code, m_busy};

    always @(negedge clk) begin
        if (m_valid) begin
            cnt_valid++;
            bq.push_back(m_out);
        end
        if (m_start) cnt_start++;
        if (m_done) cnt_done++;
        if (m_err) begin
            cnt_err++;
            last_code = m_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic p, input logic m);
        l_dp = p;
        l_dm = m;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic nb(input logic b);
        if (!b) ln = ~ln;
        send(ln, ~ln);
    endtask

    task automatic nbits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) nb(v[i]);
    endtask

    task automatic sync();
        send(1'b1, 1'b0);
        ln = 1'b1;
        nbits(32'h80, 8);
    endtask

    task automatic eop();
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        ln = 1'b1;
    endtask

    task automatic recover();
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        ln = 1'b1;
        idle(2);
    endtask

    task automatic snap();
        sv = cnt_valid;
        ss = cnt_start;
        sd = cnt_done;
        se = cnt_err;
        sb = bq.size();
    endtask

    function automatic logic [31:0] bits_since(input int b0);
        logic [31:0] v = '0;
        for (int i = b0; i < bq.size() && i - b0 < 32; i++) v[i-b0] = bq[i];
        return v;
    endfunction

    task automatic good_pkt(input string tag);
        snap();
        sync();
        nbits(32'hA5, 8);
        eop();
        idle(2);
        check({tag, "_nvalid"}, cnt_valid - sv, 8);
        check({tag, "_bits"}, bits_since(sb), 32'hA5);
        check({tag, "_start"}, cnt_start - ss, 1);
        check({tag, "_done"}, cnt_done - sd, 1);
        check({tag, "_err"}, cnt_err - se, 0);
        check({tag, "_busy"}, m_busy, 0);
    endtask

    initial begin
        idle(2);
        check("reset_outs", m_all, 0);
        rst_b = 1'b1;
        idle(2);
        check("idle_outs", m_all, 0);

        snap();
        send(1'b1, 1'b0);
        ln = 1'b1;
        nbits(32'h00, 7);
        check("sync_busy", m_busy, 1);
        check("sync_no_start", m_start, 0);
        nb(1'b1);
        check("sync_start_lat", m_start, 1);
        nbits(32'hA5, 8);
        eop();
        idle(2);
        check("a5_nvalid", cnt_valid - sv, 8);
        check("a5_bits", bits_since(sb), 32'hA5);
        check("a5_done", cnt_done - sd, 1);
        check("a5_err", cnt_err - se, 0);
        check("a5_busy", m_busy, 0);

        snap();
        sync();
        nbits(32'h1DF, 9);
        eop();
        idle(2);
        check("stuff_nvalid", cnt_valid - sv, 8);
        check("stuff_bits", bits_since(sb), 32'hFF);
        check("stuff_done", cnt_done - sd, 1);
        check("stuff_err", cnt_err - se, 0);

        snap();
        sync();
        nbits(32'h1F, 5);
        nb(1'b1);
        check("stuffviol_err", {m_err, m_code}, {1'b1, 2'd1});
        nbits(32'h3, 2);
        idle(2);
        check("stuffviol_nvalid", cnt_valid - sv, 5);
        check("stuffviol_nerr", cnt_err - se, 1);
        recover();

        snap();
        send(1'b1, 1'b0);
        ln = 1'b1;
        nbits(32'b1000, 4);
        check("shortsync_err", {m_err, m_code}, {1'b1, 2'd0});
        recover();
        check("shortsync_nostart", cnt_start - ss, 0);
        good_pkt("after_sync_err");

        snap();
        sync();
        nbits(32'h5A5, 12);
        eop();
        idle(2);
        check("align_nvalid", cnt_valid - sv, 12);
        check("align_nerr", cnt_err - se, 1);
        check("align_code", last_code, 2);
        check("align_done", cnt_done - sd, 0);
        recover();

        sync();
        nbits(32'h3C, 8);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("se0j_err", {m_err, m_code, m_done}, {1'b1, 2'd2, 1'b0});
        recover();

        sync();
        nbits(32'b101, 3);
        send(1'b1, 1'b1);
        check("se1_err", {m_err, m_code}, {1'b1, 2'd3});
        recover();

        sel = 1'b1;
        snap();
        sync();
        nbits(32'h5AA5, 16);
        check("max16_noerr", cnt_err - se, 0);
        nb(1'b0);
        check("max16_err", {m_err, m_code}, {1'b1, 2'd3});
        nbits(32'h55, 7);
        idle(2);
        check("max16_nvalid", cnt_valid - sv, 16);
        check("max16_bits", bits_since(sb), 32'h5AA5);
        recover();
        sel = 1'b0;
        idle(1);

        snap();
        sync();
        nbits(32'b0101, 4);
        check("rst_pre_valid", m_valid, 1);
        #2 rst_b = 1'b0;
        #1 check("rst_async_outs", m_all, 0);
        @(negedge clk);
        idle(2);
        rst_b = 1'b1;
        ln = 1'b1;
        idle(2);
        check("rst_no_err", cnt_err - se, 0);
        good_pkt("after_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
